dec_queue: RTL and testbench

- Parametrised decode stage with a small decoded-instruction queue between fetch and execute.
- Decodes one RV32/RV64 instruction per cycle: register indices, immediate, opcode class, ALU/LSU/branch/system hints, illegal flag.
- Stores the decoded bundles in a DEPTH-entry FIFO with valid/ready handshakes on both sides, so fetch and execute can stall independently.
- Supports a single-cycle flush for redirects.

---
 rtl/dec_queue.sv | 228 ++++++++++++++++++++++
 tb/tb_dec_queue.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_queue.sv
// Decode stage: decodes one RV32/RV64 instruction per cycle and buffers the
// decoded bundle in a DEPTH-entry FIFO between fetch and execute.
// Class one-hot bit 0 = IMM ... bit 11 = BR.
module dec_queue #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_vld,
    output logic                    in_rdy,
    input  logic [31:0]             in_inst,
    input  logic [XLEN-1:0]         in_pc,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [XLEN-1:0]         out_pc,
    output logic [31:0]             out_inst,
    output logic [4:0]              out_rd,
    output logic [4:0]              out_rs1,
    output logic [4:0]              out_rs2,
    output logic [XLEN-1:0]         out_imm,
    output logic [11:0]             out_cls,
    output logic [2:0]              out_func3,
    output logic [7:0]              out_flags,
    output logic [$clog2(DEPTH):0]  out_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum int unsigned {
        CLS_IMM    = 0,
        CLS_JALR   = 1,
        CLS_LD     = 2,
        CLS_IMM_32 = 3,
        CLS_SYS    = 4,
        CLS_AUIPC  = 5,
        CLS_LUI    = 6,
        CLS_ST     = 7,
        CLS_JAL    = 8,
        CLS_OP     = 9,
        CLS_OP_32  = 10,
        CLS_BR     = 11
    } cls_e;

    typedef enum logic [6:0] {
        OPC_IMM    = 7'h13,
        OPC_JALR   = 7'h67,
        OPC_LD     = 7'h03,
        OPC_IMM_32 = 7'h1B,
        OPC_SYS    = 7'h73,
        OPC_AUIPC  = 7'h17,
        OPC_LUI    = 7'h37,
        OPC_ST     = 7'h23,
        OPC_JAL    = 7'h6F,
        OPC_OP     = 7'h33,
        OPC_OP_32  = 7'h3B,
        OPC_BR     = 7'h63
    } opc_e;

    // Queue state
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;

    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [31:0]     inst_q  [DEPTH];
    logic [XLEN-1:0] imm_q   [DEPTH];
    logic [11:0]     cls_q   [DEPTH];
    logic [7:0]      flags_q [DEPTH];

    // Decode results for the instruction currently offered
    logic [6:0]      dec_opc;
    logic [2:0]      dec_f3;
    logic [4:0]      dec_rd, dec_rs1;
    logic [11:0]     cls_raw, dec_cls;
    logic            rv64_only, dec_illegal;
    logic            rd_link, rs1_link;
    logic            dec_call, dec_ret, dec_ecall, dec_ebreak, dec_mret;
    logic            dec_dst_vld, dec_imm_vld;
    logic [31:0]     imm32;
    logic [63:0]     imm64;
    logic [XLEN-1:0] dec_imm;
    logic [7:0]      dec_flags;

    logic            push, pop;

    assign in_rdy    = (count_q != CW'(DEPTH));
    assign out_vld   = (count_q != '0);
    assign out_count = count_q;
    assign push      = in_vld & in_rdy & ~flush;
    assign pop       = out_vld & out_rdy & ~flush;

    // Instruction decode: class, legality, immediate and hint flags
    always_comb begin
        dec_opc = in_inst[6:0];
        dec_f3  = in_inst[14:12];
        dec_rd  = in_inst[11:7];
        dec_rs1 = in_inst[19:15];

        cls_raw = '0;
        case (dec_opc)
            OPC_IMM:    cls_raw[CLS_IMM]    = 1'b1;
            OPC_JALR:   cls_raw[CLS_JALR]   = 1'b1;
            OPC_LD:     cls_raw[CLS_LD]     = 1'b1;
            OPC_IMM_32: cls_raw[CLS_IMM_32] = 1'b1;
            OPC_SYS:    cls_raw[CLS_SYS]    = 1'b1;
            OPC_AUIPC:  cls_raw[CLS_AUIPC]  = 1'b1;
            OPC_LUI:    cls_raw[CLS_LUI]    = 1'b1;
            OPC_ST:     cls_raw[CLS_ST]     = 1'b1;
            OPC_JAL:    cls_raw[CLS_JAL]    = 1'b1;
            OPC_OP:     cls_raw[CLS_OP]     = 1'b1;
            OPC_OP_32:  cls_raw[CLS_OP_32]  = 1'b1;
            OPC_BR:     cls_raw[CLS_BR]     = 1'b1;
            default:    cls_raw = '0;
        endcase

        rv64_only = cls_raw[CLS_IMM_32] | cls_raw[CLS_OP_32]
                  | (cls_raw[CLS_LD] & ((dec_f3 == 3'b011) | (dec_f3 == 3'b110)))
                  | (cls_raw[CLS_ST] & (dec_f3 == 3'b011));

        dec_illegal = (in_inst[1:0] != 2'b11) | (cls_raw == '0)
                    | ((XLEN == 32) & rv64_only);

        // Illegal entries carry no class so every derived field sees "unknown"
        dec_cls = dec_illegal ? '0 : cls_raw;

        imm32 = '0;
        if (dec_cls[CLS_IMM] | dec_cls[CLS_JALR] | dec_cls[CLS_LD]
            | dec_cls[CLS_IMM_32] | dec_cls[CLS_SYS]) begin
            imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
        end else if (dec_cls[CLS_AUIPC] | dec_cls[CLS_LUI]) begin
            imm32 = {in_inst[31:12], 12'b0};
        end else if (dec_cls[CLS_ST]) begin
            imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        end else if (dec_cls[CLS_JAL]) begin
            imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                     in_inst[20], in_inst[30:21], 1'b0};
        end else if (dec_cls[CLS_BR]) begin
            imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                     in_inst[30:25], in_inst[11:8], 1'b0};
        end
        imm64   = {{32{imm32[31]}}, imm32};
        dec_imm = imm64[XLEN-1:0];

        rd_link  = (dec_rd  == 5'd1) | (dec_rd  == 5'd5);
        rs1_link = (dec_rs1 == 5'd1) | (dec_rs1 == 5'd5);
        dec_call = (dec_cls[CLS_JAL] & rd_link)
                 | (dec_cls[CLS_JALR] & rd_link & (~rs1_link | (dec_rs1 == dec_rd)));
        dec_ret  = dec_cls[CLS_JALR] & ~rd_link & rs1_link;

        dec_ecall  = (in_inst == 32'h0000_0073);
        dec_ebreak = (in_inst == 32'h0010_0073);
        dec_mret   = (in_inst == 32'h3020_0073);

        dec_dst_vld = ~(dec_cls[CLS_ST] | dec_cls[CLS_BR]
                      | (dec_cls[CLS_SYS] & (dec_f3 == 3'b000)));
        dec_imm_vld = ~(dec_cls[CLS_OP] | dec_cls[CLS_OP_32]
                      | (dec_cls[CLS_SYS] & ~in_inst[14]));

        dec_flags = {dec_illegal, dec_ebreak, dec_ecall, dec_mret,
                     dec_call, dec_ret, dec_dst_vld, dec_imm_vld};
    end

    // Next pointer/occupancy; flush overrides any same-cycle push or pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push & ~pop)      count_d = count_q + CW'(1);
            else if (pop & ~push) count_d = count_q - CW'(1);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // PC storage: the only payload field with a defined reset value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_q[i] <= RESET_PC[XLEN-1:0];
            end
        end else if (push) begin
            pc_q[wr_ptr_q] <= in_pc;
        end
    end

    // Decoded payload storage, written on push
    always_ff @(posedge clk) begin
        if (push) begin
            inst_q[wr_ptr_q]  <= in_inst;
            imm_q[wr_ptr_q]   <= dec_imm;
            cls_q[wr_ptr_q]   <= dec_cls;
            flags_q[wr_ptr_q] <= dec_flags;
        end
    end

    assign out_pc    = pc_q[rd_ptr_q];
    assign out_inst  = inst_q[rd_ptr_q];
    assign out_rd    = out_inst[11:7];
    assign out_rs1   = out_inst[19:15];
    assign out_rs2   = out_inst[24:20];
    assign out_func3 = out_inst[14:12];
    assign out_imm   = imm_q[rd_ptr_q];
    assign out_cls   = cls_q[rd_ptr_q];
    assign out_flags = flags_q[rd_ptr_q];

endmodule

// File: tb/tb_dec_queue.sv
// Bench for dec_queue: an RV64 and an RV32 instance share one stimulus stream
// and are compared every cycle against a queue-based reference model.
module tb_dec_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_vld = 1'b0;
    logic        out_rdy = 1'b0;
    logic [31:0] in_inst = '0;
    logic [63:0] in_pc = '0;

    logic        in_rdy64, out_vld64, in_rdy32, out_vld32;
    logic [63:0] out_pc64, out_imm64;
    logic [31:0] out_pc32, out_imm32, out_inst64, out_inst32;
    logic [4:0]  rd64, rs1_64, rs2_64, rd32, rs1_32, rs2_32;
    logic [11:0] cls64, cls32;
    logic [2:0]  f3_64, f3_32, cnt64, cnt32;
    logic [7:0]  flags64, flags32;

    int checks = 0;
    int failures = 0;
    bit started = 0;

    always #5 clk = ~clk;

    dec_queue #(.XLEN(64), .DEPTH(DEPTH), .RESET_PC(64'h8000_0000)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_vld(in_vld), .in_rdy(in_rdy64),
        .in_inst(in_inst), .in_pc(in_pc), .out_vld(out_vld64), .out_rdy(out_rdy),
        .out_pc(out_pc64), .out_inst(out_inst64), .out_rd(rd64), .out_rs1(rs1_64),
        .out_rs2(rs2_64), .out_imm(out_imm64), .out_cls(cls64), .out_func3(f3_64),
        .out_flags(flags64), .out_count(cnt64)
    );

    dec_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(64'h8000_0000)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_vld(in_vld), .in_rdy(in_rdy32),
        .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_vld(out_vld32), .out_rdy(out_rdy),
        .out_pc(out_pc32), .out_inst(out_inst32), .out_rd(rd32), .out_rs1(rs1_32),
        .out_rs2(rs2_32), .out_imm(out_imm32), .out_cls(cls32), .out_func3(f3_32),
        .out_flags(flags32), .out_count(cnt32)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } ent_t;

    typedef struct packed {
        logic [11:0] cls;
        logic [63:0] imm;
        logic [7:0]  flags;
    } dec_t;

    ent_t mq[$];

    // Sign-extend the low 'bits' bits of raw using plain arithmetic
    function automatic longint unsigned sext(input longint unsigned raw, input int bits);
        if ((raw >> (bits - 1)) & 1) return raw - (longint'(1) << bits);
        return raw;
    endfunction

    function automatic dec_t ref_dec(input logic [31:0] inst, input bit rv32);
        dec_t d;
        longint unsigned w = {32'b0, inst};
        int k;
        int f3  = int'((w >> 12) & 7);
        int rd  = int'((w >> 7) & 31);
        int rs1 = int'((w >> 15) & 31);
        bit rdl, rs1l, ill, call, ret, dst, immv;
        case (inst[6:0])
            7'h13: k = 0;  7'h67: k = 1;  7'h03: k = 2;  7'h1B: k = 3;
            7'h73: k = 4;  7'h17: k = 5;  7'h37: k = 6;  7'h23: k = 7;
            7'h6F: k = 8;  7'h33: k = 9;  7'h3B: k = 10; 7'h63: k = 11;
            default: k = -1;
        endcase
        ill = (k < 0);
        if (rv32 && (k == 3 || k == 10 || (k == 2 && (f3 == 3 || f3 == 6)) || (k == 7 && f3 == 3)))
            ill = 1;
        if (ill) k = -1;
        d.cls = (k < 0) ? 12'h000 : (12'h001 << k);
        if (k == 0 || k == 1 || k == 2 || k == 3 || k == 4)
            d.imm = sext(w >> 20, 12);
        else if (k == 5 || k == 6)
            d.imm = sext(w & 64'hFFFF_F000, 32);
        else if (k == 7)
            d.imm = sext(((w >> 25) << 5) | ((w >> 7) & 31), 12);
        else if (k == 8)
            d.imm = sext((((w >> 31) & 1) << 20) | (((w >> 12) & 255) << 12)
                         | (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1), 21);
        else if (k == 11)
            d.imm = sext((((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11)
                         | (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1), 13);
        else
            d.imm = 0;
        rdl  = (rd == 1 || rd == 5);
        rs1l = (rs1 == 1 || rs1 == 5);
        call = (k == 8 && rdl) || (k == 1 && rdl && (!rs1l || rs1 == rd));
        ret  = (k == 1 && !rdl && rs1l);
        dst  = !(k == 7 || k == 11 || (k == 4 && f3 == 0));
        immv = !(k == 9 || k == 10 || (k == 4 && ((f3 & 4) == 0)));
        d.flags = {ill, inst == 32'h0010_0073, inst == 32'h0000_0073, inst == 32'h3020_0073,
                   call, ret, dst, immv};
        return d;
    endfunction

    // Model state update mirrors the handshake rules on each clock edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
        end else begin
            bit do_push, do_pop;
            do_push = in_vld && (mq.size() != DEPTH) && !flush;
            do_pop  = (mq.size() != 0) && out_rdy && !flush;
            if (flush) mq.delete();
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back('{inst: in_inst, pc: in_pc});
        end
    end

    // Compare both DUTs against the model away from the active edge
    always @(negedge clk) begin
        if (started) begin
            chk("count64", {61'b0, cnt64}, mq.size());
            chk("count32", {61'b0, cnt32}, mq.size());
            chk("vld64", {63'b0, out_vld64}, {63'b0, mq.size() != 0});
            chk("vld32", {63'b0, out_vld32}, {63'b0, mq.size() != 0});
            chk("rdy64", {63'b0, in_rdy64}, {63'b0, mq.size() != DEPTH});
            chk("rdy32", {63'b0, in_rdy32}, {63'b0, mq.size() != DEPTH});
            if (mq.size() != 0) begin
                dec_t e64, e32;
                logic [31:0] hi;
                hi  = mq[0].inst;
                e64 = ref_dec(hi, 0);
                e32 = ref_dec(hi, 1);
                chk("pc64", out_pc64, mq[0].pc);
                chk("pc32", {32'b0, out_pc32}, {32'b0, mq[0].pc[31:0]});
                chk("inst64", {32'b0, out_inst64}, {32'b0, hi});
                chk("inst32", {32'b0, out_inst32}, {32'b0, hi});
                chk("regs64", {49'b0, rd64, rs1_64, rs2_64}, {49'b0, hi[11:7], hi[19:15], hi[24:20]});
                chk("regs32", {49'b0, rd32, rs1_32, rs2_32}, {49'b0, hi[11:7], hi[19:15], hi[24:20]});
                chk("func3_64", {61'b0, f3_64}, {61'b0, hi[14:12]});
                chk("func3_32", {61'b0, f3_32}, {61'b0, hi[14:12]});
                chk("imm64", out_imm64, e64.imm);
                chk("imm32", {32'b0, out_imm32}, {32'b0, e32.imm[31:0]});
                chk("cls64", {52'b0, cls64}, {52'b0, e64.cls});
                chk("cls32", {52'b0, cls32}, {52'b0, e32.cls});
                chk("flags64", {56'b0, flags64}, {56'b0, e64.flags});
                chk("flags32", {56'b0, flags32}, {56'b0, e32.flags});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] inst, input logic [63:0] pc);
        in_vld  = v;
        in_inst = inst;
        in_pc   = pc;
    endtask

    function automatic logic [4:0] pick_reg();
        logic [4:0] regs [4];
        regs[0] = 5'd0;
        regs[1] = 5'd1;
        regs[2] = 5'd5;
        regs[3] = 5'($urandom);
        return regs[$urandom_range(0, 3)];
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [12];
        logic [31:0] sys [3];
        logic [31:0] r;
        int sel;
        ops = '{7'h13, 7'h67, 7'h03, 7'h1B, 7'h73, 7'h17, 7'h37, 7'h23, 7'h6F, 7'h33, 7'h3B, 7'h63};
        sys = '{32'h0000_0073, 32'h0010_0073, 32'h3020_0073};
        r   = $urandom;
        sel = $urandom_range(0, 15);
        if (sel < 12) begin
            r[6:0]   = ops[sel];
            r[11:7]  = pick_reg();
            r[19:15] = pick_reg();
        end else if (sel == 12) begin
            r = sys[$urandom_range(0, 2)];
        end else if (sel == 14) begin
            r[6:0] = ops[$urandom_range(0, 11)];
            r[1:0] = 2'($urandom_range(0, 2));
        end
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Pin the reference model against hand-decoded instructions
        chk("model_jal_imm",   ref_dec(32'h008000EF, 0).imm,   64'd8);
        chk("model_jal_flags", {56'b0, ref_dec(32'h008000EF, 0).flags}, 64'h0B);
        chk("model_ret_flags", {56'b0, ref_dec(32'h00008067, 0).flags}, 64'h07);
        chk("model_addi_imm",  ref_dec(32'hFFF10093, 0).imm,   64'hFFFF_FFFF_FFFF_FFFF);
        chk("model_addiw32",   {56'b0, ref_dec(32'h0010009B, 1).flags}, 64'h83);
        chk("model_ebreak",    {56'b0, ref_dec(32'h00100073, 0).flags}, 64'h40);

        #2 rst_n = 1'b0;
        #1;
        chk("rst_vld", {63'b0, out_vld64}, 64'd0);
        chk("rst_cnt", {61'b0, cnt64}, 64'd0);
        chk("rst_rdy", {63'b0, in_rdy64}, 64'd1);
        step();
        step();
        rst_n = 1'b1;
        started = 1;

        // addi x1, x2, -1 with consumer ready
        out_rdy = 1'b1;
        drive(1, 32'hFFF10093, 64'h8000_0000);
        step();
        drive(0, 0, 0);
        chk("addi_vld", {63'b0, out_vld64}, 64'd1);
        chk("addi_rd",  {59'b0, rd64}, 64'd1);
        chk("addi_rs1", {59'b0, rs1_64}, 64'd2);
        chk("addi_imm", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_cls", {52'b0, cls64}, 64'h001);
        chk("addi_flags", {56'b0, flags64}, 64'h03);
        step();
        chk("addi_gone", {63'b0, out_vld64}, 64'd0);

        // jal x1,+8 then jalr x0,0(x1)
        out_rdy = 1'b0;
        drive(1, 32'h008000EF, 64'h8000_0004);
        step();
        drive(1, 32'h00008067, 64'h8000_0008);
        step();
        drive(0, 0, 0);
        chk("jal_imm", out_imm64, 64'd8);
        chk("jal_cls", {52'b0, cls64}, 64'h100);
        chk("jal_call_ret", {62'b0, flags64[3:2]}, 64'b10);
        out_rdy = 1'b1;
        step();
        chk("jalr_call_ret", {62'b0, flags64[3:2]}, 64'b01);
        chk("jalr_imm", out_imm64, 64'd0);
        step();
        out_rdy = 1'b0;

        // Fill past capacity, then drain
        for (int n = 0; n < 6; n++) begin
            drive(1, 32'h00000013 | (32'(n) << 20), 64'h1000 + 64'(4 * n));
            step();
        end
        drive(0, 0, 0);
        chk("full_cnt", {61'b0, cnt64}, 64'd4);
        chk("full_rdy", {63'b0, in_rdy64}, 64'd0);
        chk("full_head", out_pc64, 64'h1000);
        out_rdy = 1'b1;
        step();
        chk("drain_rdy", {63'b0, in_rdy64}, 64'd1);
        chk("drain_pc1", out_pc64, 64'h1004);
        repeat (3) step();
        out_rdy = 1'b0;

        // Flush with a concurrent push and pop request
        for (int n = 0; n < 3; n++) begin
            drive(1, 32'h00000033, 64'h2000 + 64'(4 * n));
            step();
        end
        drive(1, 32'h00000013, 64'h3000);
        flush = 1'b1;
        out_rdy = 1'b1;
        step();
        flush = 1'b0;
        drive(0, 0, 0);
        out_rdy = 1'b0;
        chk("flush_cnt", {61'b0, cnt64}, 64'd0);
        chk("flush_vld", {63'b0, out_vld64}, 64'd0);
        step();

        // RV64-only opcode and an all-zero word
        drive(1, 32'h0010009B, 64'h4000);
        step();
        drive(1, 32'h00000000, 64'h4004);
        step();
        drive(0, 0, 0);
        chk("addiw32_ill", {63'b0, flags32[7]}, 64'd1);
        chk("addiw32_cls", {52'b0, cls32}, 64'h000);
        chk("addiw64_ill", {63'b0, flags64[7]}, 64'd0);
        chk("addiw64_cls", {52'b0, cls64}, 64'h008);
        chk("addiw64_imm", out_imm64, 64'd1);
        out_rdy = 1'b1;
        step();
        chk("zero32_ill", {63'b0, flags32[7]}, 64'd1);
        chk("zero32_cls", {52'b0, cls32}, 64'h000);
        step();
        out_rdy = 1'b0;

        // Asynchronous reset mid-cycle with entries queued
        drive(1, 32'h00100073, 64'h5000);
        step();
        step();
        drive(0, 0, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_vld", {63'b0, out_vld64}, 64'd0);
        chk("arst_cnt", {61'b0, cnt64}, 64'd0);
        step();
        rst_n = 1'b1;
        drive(1, 32'h00100073, 64'h5008);
        step();
        drive(0, 0, 0);
        chk("ebreak_flags", {56'b0, flags64}, 64'h40);
        chk("ebreak_cls", {52'b0, cls64}, 64'h010);
        out_rdy = 1'b1;
        step();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 3) != 0, rand_inst(), {$urandom, $urandom});
            out_rdy = ($urandom_range(0, 2) != 0);
            flush   = ($urandom_range(0, 31) == 0);
            step();
        end
        drive(0, 0, 0);
        flush = 1'b0;
        out_rdy = 1'b1;
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
